// File: rtl/fifo_mux_out_if.sv
// fifo_mux_out_if: push/pop/status bundle for fifo_mux_out; the err signal exists only with FIFO_ERR_EN.
interface fifo_mux_out_if #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
);
    logic [DATA_W-1:0]        data_in;
    logic                     valid_in;
    logic                     pop;
    logic [DATA_W-1:0]        data_out;
    logic                     valid_out;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
`ifdef FIFO_ERR_EN
    logic                     err;
    modport master (output data_in, valid_in, pop,
                    input  data_out, valid_out, full, empty, almost_full, almost_empty, count, err);
    modport slave  (input  data_in, valid_in, pop,
                    output data_out, valid_out, full, empty, almost_full, almost_empty, count, err);
`else
    modport master (output data_in, valid_in, pop,
                    input  data_out, valid_out, full, empty, almost_full, almost_empty, count);
    modport slave  (input  data_in, valid_in, pop,
                    output data_out, valid_out, full, empty, almost_full, almost_empty, count);
`endif
endinterface

// File: rtl/fifo_mux_out.sv
// fifo_mux_out: FIFO behind a 2:1 mux with registered one-cycle read; sticky err flag when FIFO_ERR_EN is defined.
module fifo_mux_out #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4,
    parameter int AF_THR = 3,
    parameter int AE_THR = 1
) (
    input logic           clk,
    input logic           reset,
    fifo_mux_out_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              full, empty, push_ok, pop_ok;

    // Accept decisions and next-state; a pop frees the slot a simultaneous push needs when full.
    always_comb begin
        full        = count_q == CW'(DEPTH);
        empty       = count_q == '0;
        pop_ok      = bus.pop && !empty;
        push_ok     = bus.valid_in && (!full || pop_ok);
        wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + CW'(push_ok) - CW'(pop_ok);
        valid_out_d = pop_ok;
        data_out_d  = pop_ok ? mem[rd_ptr_q] : data_out_q;
    end

    // Storage has no reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem[wr_ptr_q] <= bus.data_in;
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = count_q >= CW'(AF_THR);
    assign bus.almost_empty = count_q <= CW'(AE_THR);

`ifdef FIFO_ERR_EN
    logic err_q, err_d;

    // Sticky flag: overflow is a push into a full FIFO with no pop, underflow a pop from empty.
    always_comb begin
        err_d = err_q | (bus.valid_in & full & ~bus.pop) | (bus.pop & empty);
    end

    // Err holds until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bus.err = err_q;
`endif
endmodule

// File: doc/fifo_mux_out.md
FIFO_MUX_OUT -- requirements
Module: fifo_mux_out

Interface
REQ-001 Parameter DATA_W, default 2, width of each stored word; this matches the 2-bit mux output.
REQ-002 Parameter DEPTH, default 4, number of entries; it SHALL be a power of two and at least 2.
REQ-003 Parameter AF_THR, default 3, count at or above which almost_full asserts.
REQ-004 Parameter AE_THR, default 1, count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 data_in  input  DATA_W  word from the upstream 2:1 mux data output.
REQ-008 valid_in  input  1  push request; upstream mux valid output drives it.
REQ-009 pop  input  1  read request from the downstream consumer.
REQ-010 data_out  output  DATA_W  registered read word.
REQ-011 valid_out  output  1  high for exactly one cycle when data_out carries a popped word.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 almost_full  output  1  count >= AF_THR.
REQ-015 almost_empty  output  1  count <= AE_THR.
REQ-016 count  output  log2(DEPTH)+1  number of stored words.
REQ-017 err  output  1  sticky overflow/underflow flag; present only when FIFO_ERR_EN is defined.

Function
REQ-018 Push: valid_in=1 and (full=0 or an accepted pop in the same cycle) SHALL write data_in at the write pointer and advance the write pointer by 1 modulo DEPTH.
REQ-019 Pop: pop=1 and empty=0 SHALL read the head entry into data_out at the next edge, set valid_out=1 and advance the read pointer by 1 modulo DEPTH.
REQ-020 Read latency is one cycle: the word is valid on the edge after pop is sampled.
REQ-021 When no pop is accepted, valid_out SHALL be 0 and data_out SHALL hold its last value.
REQ-022 Order is strict first-in first-out; pointers wrap from DEPTH-1 to 0 with no bubble.
REQ-023 count: +1 on an accepted push only; -1 on an accepted pop only; unchanged when both or neither are accepted.
REQ-024 full, empty, almost_full and almost_empty are combinational decodes of the registered count.
REQ-025 Push while full without a pop: the word is dropped, and storage, pointers and count are unchanged (overflow).
REQ-026 Push and pop together while full: both are accepted and count stays DEPTH.
REQ-027 Pop while empty: ignored, valid_out=0 (underflow); if valid_in is also 1, the push is accepted and count becomes 1.
REQ-028 Storage is not cleared on reset; only pointers, count and outputs reset.

Reset
REQ-029 reset=1 SHALL immediately, without waiting for clk, force: pointers=0, count=0, data_out=0, valid_out=0, err=0 (when present).
REQ-030 While reset=1, push and pop are ignored; the first operation is sampled on the first rising edge after reset falls.
REQ-031 Reset asserted mid-operation discards all stored words; empty=1 follows immediately.

Configuration
REQ-032 Macro FIFO_ERR_EN defined: err port exists; it sets on the edge after any overflow (REQ-025) or underflow (REQ-027) and stays 1 until reset.
REQ-033 Macro FIFO_ERR_EN undefined: err port and its logic are absent; overflow and underflow behaviour is otherwise identical.

Verification
REQ-034 Reset, then push 11, 10, 01, 00 on consecutive cycles -> count 1,2,3,4; almost_full=1 at count 3; full=1 at count 4.
REQ-035 From the full state of REQ-034, pop on 4 cycles -> data_out 11,10,01,00, each with valid_out=1 one cycle after its pop; empty=1 at the end.
REQ-036 Full, then push 11 without pop -> count stays 4, next pops still return the original order; err=1 with FIFO_ERR_EN.
REQ-037 Full, then push 10 and pop together -> data_out=oldest word, count stays 4, 10 is returned last.
REQ-038 Empty, then pop with push 01 -> valid_out=0, count=1; next pop returns 01; err=1 with FIFO_ERR_EN.
REQ-039 Push 6 words with interleaved pops to wrap the pointers, then assert reset between edges -> count=0, valid_out=0, empty=1 immediately, without a clock edge.
